// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use, MUL/DIV occupancy and data-memory wait hazards.
module pipe_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_muldiv,
  input  logic             id_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             stall_memwb,
  output logic             bubble_idex,
  output logic             bubble_exmem,
  output logic             flush_ifid,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MC_W = $clog2(MULDIV_LAT);
  localparam logic [MC_W-1:0] MC_INIT =
    MC_W'(MULDIV_LAT - 2);

  typedef enum logic [1:0] {
    RUN,
    MULDIV,
    MEMWAIT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            saved_md;
  logic            saved_nx;
  logic [MC_W-1:0] mcnt;
  logic [MC_W-1:0] mcnt_nx;

  logic memstall;
  logic load_use;
  logic rs_hit;
  logic rt_hit;
  logic eff_md;
  logic mcnt_zero;
  logic md_hold;
  logic lu_hold;
  logic sel_mem;
  logic sel_md_run;
  logic sel_md_last;
  logic sel_md_start;
  logic sel_idle;
  logic spc;
  logic sid;

  assign memstall  = dmem_req & ~dmem_ready;
  assign mcnt_zero = (mcnt == '0);

  // Leaving MEMWAIT behaves as the saved state in the release cycle.
  assign eff_md = (state == MULDIV)
                | ((state == MEMWAIT) & saved_md);

  assign rs_hit = id_uses_rs & (id_rs == ex_rd);
  assign rt_hit = id_uses_rt & (id_rt == ex_rd);

  assign load_use = ex_mem_read
                  & (ex_rd != '0)
                  & (rs_hit | rt_hit);

  assign sel_mem      = memstall;
  assign sel_md_run   = ~memstall & eff_md & ~mcnt_zero;
  assign sel_md_last  = ~memstall & eff_md & mcnt_zero;
  assign sel_md_start = ~memstall & ~eff_md & ex_is_muldiv;
  assign sel_idle     = ~memstall & ~eff_md & ~ex_is_muldiv;

  always_comb begin
    state_nx = state;
    saved_nx = saved_md;
    mcnt_nx  = mcnt;
    md_hold  = 1'b0;
    lu_hold  = 1'b0;
    unique case (1'b1)
      sel_mem: begin
        state_nx = MEMWAIT;
        if (state != MEMWAIT) begin
          saved_nx = (state == MULDIV);
        end
      end
      sel_md_run: begin
        md_hold  = 1'b1;
        mcnt_nx  = mcnt - 1'b1;
        state_nx = MULDIV;
      end
      sel_md_last: begin
        lu_hold  = load_use;
        state_nx = RUN;
      end
      sel_md_start: begin
        md_hold  = 1'b1;
        mcnt_nx  = MC_INIT;
        state_nx = MULDIV;
      end
      sel_idle: begin
        lu_hold  = load_use;
        state_nx = RUN;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

  assign spc = memstall | md_hold | lu_hold;
  assign sid = memstall | md_hold;

  assign stall_pc     = Reset & spc;
  assign stall_ifid   = Reset & spc;
  assign stall_idex   = Reset & sid;
  assign stall_exmem  = Reset & memstall;
  assign stall_memwb  = Reset & memstall;
  assign bubble_idex  = Reset & lu_hold;
  assign bubble_exmem = Reset & md_hold;
  assign flush_ifid   = Reset & id_branch_taken & ~spc;
  assign muldiv_busy  = Reset & eff_md;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= RUN;
      saved_md <= 1'b0;
      mcnt     <= '0;
    end else begin
      state    <= state_nx;
      saved_md <= saved_nx;
      mcnt     <= mcnt_nx;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cycles <= '0;
    end else if (stall_pc) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a cycle-count model.
// A second instance with a 4-bit counter exercises wrap-around.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_is_muldiv;
  logic       id_branch_taken;
  logic       dmem_req;
  logic       dmem_ready;

  logic        s_pc, s_ifid, s_idex, s_exmem, s_memwb;
  logic        b_idex, b_exmem, f_ifid, busy;
  logic [31:0] cnt32;
  logic        t_pc, t_ifid, t_idex, t_exmem, t_memwb;
  logic        t_bidex, t_bexmem, t_fifid, t_busy;
  logic [3:0]  cnt4;

  logic [8:0] ctl;
  logic [8:0] ctl4;

  assign ctl  = {s_pc, s_ifid, s_idex, s_exmem, s_memwb,
                 b_idex, b_exmem, f_ifid, busy};
  assign ctl4 = {t_pc, t_ifid, t_idex, t_exmem, t_memwb,
                 t_bidex, t_bexmem, t_fifid, t_busy};

  pipe_hazard_ctrl #(.REG_W(5), .MULDIV_LAT(LAT), .CNT_W(32)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_is_muldiv(ex_is_muldiv),
    .id_branch_taken(id_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(s_pc), .stall_ifid(s_ifid),
    .stall_idex(s_idex), .stall_exmem(s_exmem),
    .stall_memwb(s_memwb),
    .bubble_idex(b_idex), .bubble_exmem(b_exmem),
    .flush_ifid(f_ifid), .muldiv_busy(busy),
    .stall_cycles(cnt32)
  );

  pipe_hazard_ctrl #(.REG_W(5), .MULDIV_LAT(LAT), .CNT_W(4)) u_w4 (
    .Clk(Clk), .Reset(Reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_is_muldiv(ex_is_muldiv),
    .id_branch_taken(id_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(t_pc), .stall_ifid(t_ifid),
    .stall_idex(t_idex), .stall_exmem(t_exmem),
    .stall_memwb(t_memwb),
    .bubble_idex(t_bidex), .bubble_exmem(t_bexmem),
    .flush_ifid(t_fifid), .muldiv_busy(t_busy),
    .stall_cycles(cnt4)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       urs;
    logic       urt;
    logic       mr;
    logic       md;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  int     n_chk = 0;
  int     n_err = 0;
  int     md_left = 0;
  longint stalls = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input stim_t s);
    id_rs           = s.rs;
    id_rt           = s.rt;
    ex_rd           = s.rd;
    id_uses_rs      = s.urs;
    id_uses_rt      = s.urt;
    ex_mem_read     = s.mr;
    ex_is_muldiv    = s.md;
    id_branch_taken = s.br;
    dmem_req        = s.req;
    dmem_ready      = s.rdy;
  endtask

  // md_left: EX cycles still owed by the MUL/DIV in flight.
  task automatic cycle(input stim_t s);
    logic ms, lu, hold, use_lu, spc, sid, bid, mbusy;
    logic [8:0] e;
    @(negedge Clk);
    apply(s);
    #1;
    ms = s.req & ~s.rdy;
    lu = s.mr && (s.rd != 0)
       && ((s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd));
    mbusy  = (md_left > 0);
    hold   = 1'b0;
    use_lu = 1'b0;
    if (ms) begin
    end else if (md_left > 1) begin
      hold = 1'b1;
      md_left--;
    end else if (md_left == 1) begin
      use_lu  = 1'b1;
      md_left = 0;
    end else if (s.md) begin
      hold    = 1'b1;
      md_left = LAT - 1;
    end else begin
      use_lu = 1'b1;
    end
    bid = use_lu & lu;
    spc = ms | hold | bid;
    sid = ms | hold;
    e = {spc, spc, sid, ms, ms, bid, hold,
         s.br & ~spc, mbusy};
    chk("ctl", 64'(ctl), 64'(e));
    chk("ctl4", 64'(ctl4), 64'(e));
    chk("cnt", 64'(cnt32), 64'(stalls[31:0]));
    chk("cnt4", 64'(cnt4), 64'(stalls[3:0]));
    if (spc) stalls++;
  endtask

  task automatic do_reset();
    stim_t s;
    s = '0;
    s.md  = 1'b1;
    s.req = 1'b1;
    s.br  = 1'b1;
    s.mr  = 1'b1;
    @(negedge Clk);
    apply(s);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst_ctl", 64'(ctl), 64'd0);
    chk("rst_ctl4", 64'(ctl4), 64'd0);
    chk("rst_cnt", 64'(cnt32), 64'd0);
    @(posedge Clk);
    #1;
    chk("rst_hold", 64'(ctl), 64'd0);
    @(negedge Clk);
    apply('0);
    Reset   = 1'b1;
    md_left = 0;
    stalls  = 0;
  endtask

  stim_t idle, lu8, s;

  initial begin
    Reset = 1'b0;
    apply('0);
    idle = '0;
    lu8 = '0;
    lu8.mr  = 1'b1;
    lu8.rd  = 5'd8;
    lu8.urt = 1'b1;
    lu8.rt  = 5'd8;

    do_reset();
    cycle(idle);

    cycle(lu8);
    chk("lu_stall", 64'({s_pc, s_ifid, b_idex}), 64'd7);
    s = lu8;
    s.rd = 5'd0;
    s.rt = 5'd0;
    cycle(s);
    chk("lu_r0", 64'({s_pc, b_idex}), 64'd0);

    do_reset();
    s = idle;
    s.md = 1'b1;
    for (int i = 0; i < LAT; i++) cycle(s);
    chk("md_release", 64'(s_pc), 64'd0);
    chk("md_cnt", 64'(cnt32), 64'd3);
    cycle(idle);

    do_reset();
    s = idle;
    s.md = 1'b1;
    cycle(s);
    cycle(s);
    s.req = 1'b1;
    cycle(s);
    cycle(s);
    chk("mw_stalls", 64'(ctl[8:4]), 64'h1f);
    s.rdy = 1'b1;
    cycle(s);
    s.req = 1'b0;
    cycle(s);
    chk("mw_release", 64'(s_pc), 64'd0);
    chk("mw_cnt", 64'(cnt32), 64'd5);
    cycle(idle);

    s = idle;
    s.br = 1'b1;
    cycle(s);
    chk("flush", 64'(f_ifid), 64'd1);
    s = lu8;
    s.br = 1'b1;
    cycle(s);
    chk("flush_lu", 64'(f_ifid), 64'd0);
    s = idle;
    s.br = 1'b1;
    cycle(s);
    chk("flush_next", 64'(f_ifid), 64'd1);

    do_reset();
    for (int i = 0; i < 15; i++) cycle(lu8);
    cycle(idle);
    chk("w4_pre", 64'(cnt4), 64'd15);
    cycle(lu8);
    cycle(idle);
    chk("w4_wrap", 64'(cnt4), 64'd0);
    chk("w32_nowrap", 64'(cnt32), 64'd16);

    // reset while a MUL/DIV has one stall cycle left
    s = idle;
    s.md = 1'b1;
    cycle(s);
    cycle(s);
    do_reset();
    cycle(idle);
    chk("post_rst_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      s.rs  = 5'($urandom_range(0, 3));
      s.rt  = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.urs = 1'($urandom);
      s.urt = 1'($urandom);
      s.mr  = 1'($urandom);
      s.md  = ($urandom_range(0, 5) == 0);
      s.br  = 1'($urandom);
      s.req = ($urandom_range(0, 3) == 0);
      s.rdy = 1'($urandom);
      cycle(s);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
